// File: rtl/pump_pkg.sv
// Shared state encodings, default timing constants and ramp arithmetic for the pump sequencer.
package pump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RAMP_UP   = 3'd1,
        ST_RUN       = 3'd2,
        ST_RAMP_DOWN = 3'd3,
        ST_COOLDOWN  = 3'd4,
        ST_FAULT     = 3'd5
    } pump_state_t;

    localparam int DEF_TICK_DIV    = 50000;
    localparam int DEF_RAMP_STEP   = 8;
    localparam int DEF_AUTO_SPEED  = 200;
    localparam int DEF_COOLDOWN_MS = 2000;
    localparam int DEF_MAX_RUN_MS  = 60000;

    // The sum is widened to 9 bits so a step near 255 saturates at the target instead of wrapping.
    function automatic logic [7:0] ramp_up_step(input logic [7:0] cur, input logic [7:0] step,
                                                input logic [7:0] tgt);
        logic [8:0] sum;
        sum = {1'b0, cur} + {1'b0, step};
        return (sum >= {1'b0, tgt}) ? tgt : sum[7:0];
    endfunction

    function automatic logic [7:0] ramp_down_step(input logic [7:0] cur, input logic [7:0] step);
        return (cur > step) ? (cur - step) : 8'd0;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clocks (1 ms at 50 MHz by default).
module ms_tick_gen
    import pump_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = (count == CW'(TICK_DIV - 1));

endmodule

// File: rtl/pump_sequencer.sv
// Pump start/ramp/run/stop sequencer with dry-run fault lockout and cooldown.
// Optional run watchdog is built in when PUMP_WATCHDOG_EN is defined.
module pump_sequencer
    import pump_pkg::*;
#(
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int RAMP_STEP   = DEF_RAMP_STEP,
    parameter int AUTO_SPEED  = DEF_AUTO_SPEED,
    parameter int COOLDOWN_MS = DEF_COOLDOWN_MS,
    parameter int MAX_RUN_MS  = DEF_MAX_RUN_MS
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req_manual,
    input  logic [7:0] manual_speed,
    input  logic       req_auto,
    input  logic       stop,
    input  logic       dry_fault,
    input  logic       fault_clr,
    output logic       pump_en,
    output logic [7:0] pump_speed,
    output logic [2:0] state,
    output logic       timeout
);

    localparam int CCW = (COOLDOWN_MS > 1) ? $clog2(COOLDOWN_MS + 1) : 1;
    localparam logic [7:0] STEP = 8'(RAMP_STEP);

    logic tick;

    ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    // Two-flop synchronizers for the asynchronous level inputs
    logic man_s1, man_s2, dry_s1, dry_s2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            man_s1 <= 1'b0;
            man_s2 <= 1'b0;
            dry_s1 <= 1'b0;
            dry_s2 <= 1'b0;
        end else begin
            man_s1 <= req_manual;
            man_s2 <= man_s1;
            dry_s1 <= dry_fault;
            dry_s2 <= dry_s1;
        end
    end

    pump_state_t    state_q, state_nxt;
    logic [7:0]     speed_q, speed_nxt;
    logic [7:0]     target_q, target_nxt;
    logic           manual_src_q, manual_src_nxt;
    logic [CCW-1:0] cool_q, cool_nxt;
    logic           req_live;

`ifdef PUMP_WATCHDOG_EN
    localparam int RCW = (MAX_RUN_MS > 1) ? $clog2(MAX_RUN_MS + 1) : 1;
    logic [RCW-1:0] run_q, run_nxt;
    logic           timeout_q, timeout_nxt;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            speed_q      <= 8'd0;
            target_q     <= 8'd0;
            manual_src_q <= 1'b0;
            cool_q       <= '0;
`ifdef PUMP_WATCHDOG_EN
            run_q        <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_nxt;
            speed_q      <= speed_nxt;
            target_q     <= target_nxt;
            manual_src_q <= manual_src_nxt;
            cool_q       <= cool_nxt;
`ifdef PUMP_WATCHDOG_EN
            run_q        <= run_nxt;
            timeout_q    <= timeout_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt      = state_q;
        speed_nxt      = speed_q;
        target_nxt     = target_q;
        manual_src_nxt = manual_src_q;
        cool_nxt       = cool_q;
`ifdef PUMP_WATCHDOG_EN
        run_nxt        = run_q;
        timeout_nxt    = timeout_q;
`endif
        // Only the request that started this run can keep it alive
        req_live = manual_src_q ? man_s2 : req_auto;

        if (dry_s2) begin
            state_nxt = ST_FAULT;
            speed_nxt = 8'd0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (man_s2 && (manual_speed != 8'd0)) begin
                        target_nxt     = manual_speed;
                        manual_src_nxt = 1'b1;
                        state_nxt      = ST_RAMP_UP;
                    end else if (req_auto) begin
                        target_nxt     = 8'(AUTO_SPEED);
                        manual_src_nxt = 1'b0;
                        state_nxt      = ST_RAMP_UP;
                    end
`ifdef PUMP_WATCHDOG_EN
                    if (state_nxt == ST_RAMP_UP) begin
                        timeout_nxt = 1'b0;
                        run_nxt     = '0;
                    end
`endif
                end
                ST_RAMP_UP: begin
                    if (stop || !req_live) begin
                        state_nxt = ST_RAMP_DOWN;
                    end else if (speed_q == target_q) begin
                        state_nxt = ST_RUN;
                    end else if (tick) begin
                        speed_nxt = ramp_up_step(speed_q, STEP, target_q);
                    end
                end
                ST_RUN: begin
                    speed_nxt = target_q;
                    if (stop || !req_live) begin
                        state_nxt = ST_RAMP_DOWN;
                    end
`ifdef PUMP_WATCHDOG_EN
                    else if (tick) begin
                        if (run_q == RCW'(MAX_RUN_MS - 1)) begin
                            timeout_nxt = 1'b1;
                            state_nxt   = ST_RAMP_DOWN;
                        end else begin
                            run_nxt = run_q + RCW'(1);
                        end
                    end
`endif
                end
                ST_RAMP_DOWN: begin
                    if (speed_q == 8'd0) begin
                        state_nxt = ST_COOLDOWN;
                        cool_nxt  = '0;
                    end else if (tick) begin
                        speed_nxt = ramp_down_step(speed_q, STEP);
                    end
                end
                ST_COOLDOWN: begin
                    if (tick) begin
                        if (cool_q == CCW'(COOLDOWN_MS - 1)) begin
                            state_nxt = ST_IDLE;
                            cool_nxt  = '0;
                        end else begin
                            cool_nxt = cool_q + CCW'(1);
                        end
                    end
                end
                ST_FAULT: begin
                    speed_nxt = 8'd0;
                    if (fault_clr) begin
                        state_nxt = ST_COOLDOWN;
                        cool_nxt  = '0;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    speed_nxt = 8'd0;
                end
            endcase
        end
    end

    assign pump_en    = (state_q == ST_RAMP_UP) || (state_q == ST_RUN) || (state_q == ST_RAMP_DOWN);
    assign pump_speed = speed_q;
    assign state      = state_q;

`ifdef PUMP_WATCHDOG_EN
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pump_sequencer.sv
// Self-checking bench for pump_sequencer with a small tick divider; speed steps are scoreboarded.
module tb_pump_sequencer;

    localparam int TICK_DIV    = 10;
    localparam int RAMP_STEP   = 16;
    localparam int AUTO_SPEED  = 200;
    localparam int COOLDOWN_MS = 3;
    localparam int MAX_RUN_MS  = 5;

    localparam logic [2:0] S_IDLE = 3'd0, S_UP = 3'd1, S_RUN = 3'd2,
                           S_DOWN = 3'd3, S_COOL = 3'd4, S_FAULT = 3'd5;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       req_manual, req_auto, stop, dry_fault, fault_clr;
    logic [7:0] manual_speed;
    logic       pump_en, timeout;
    logic [7:0] pump_speed;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    pump_sequencer #(
        .TICK_DIV(TICK_DIV), .RAMP_STEP(RAMP_STEP), .AUTO_SPEED(AUTO_SPEED),
        .COOLDOWN_MS(COOLDOWN_MS), .MAX_RUN_MS(MAX_RUN_MS)
    ) dut (
        .clk(clk), .reset_n(reset_n), .req_manual(req_manual), .manual_speed(manual_speed),
        .req_auto(req_auto), .stop(stop), .dry_fault(dry_fault), .fault_clr(fault_clr),
        .pump_en(pump_en), .pump_speed(pump_speed), .state(state), .timeout(timeout)
    );

    task automatic wait_state(input logic [2:0] s, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (state === s) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        checks++; if (state !== S_IDLE) begin errors++; $display("FAIL reset_state got %0d want %0d", state, S_IDLE); end
        checks++; if (pump_en !== 1'b0) begin errors++; $display("FAIL reset_pump_en got %b want 0", pump_en); end
        checks++; if (pump_speed !== 8'd0) begin errors++; $display("FAIL reset_speed got %0d want 0", pump_speed); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", timeout); end
    endtask

    task automatic test_auto_ramp();
        logic [7:0] prev, e;
        int c_hit, c_run;
        c_hit = -100;
        c_run = -1;
        for (int v = RAMP_STEP; v < AUTO_SPEED; v += RAMP_STEP) exp_q.push_back(8'(v));
        exp_q.push_back(8'(AUTO_SPEED));
        prev = pump_speed;
        req_auto = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (pump_speed !== prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL auto_ramp unexpected speed %0d", pump_speed);
                end else begin
                    e = exp_q.pop_front();
                    if (pump_speed !== e) begin errors++; $display("FAIL auto_ramp speed got %0d want %0d", pump_speed, e); end
                end
                if (pump_speed === 8'(AUTO_SPEED)) c_hit = c;
                prev = pump_speed;
            end
            if (state === S_RUN) begin
                c_run = c;
                break;
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL auto_ramp missing %0d steps want 0", exp_q.size()); end
        exp_q.delete();
        checks++; if (c_run - c_hit != 1) begin errors++; $display("FAIL auto_run_entry cycles after target got %0d want 1", c_run - c_hit); end
        checks++; if (state !== S_RUN || pump_en !== 1'b1 || pump_speed !== 8'(AUTO_SPEED)) begin
            errors++; $display("FAIL auto_run state/en/speed got %0d/%b/%0d want 2/1/200", state, pump_en, pump_speed);
        end
    endtask

    task automatic test_drop_cooldown();
        logic [7:0] prev, e;
        int n;
        bit ok;
        for (int v = AUTO_SPEED - RAMP_STEP; v > 0; v -= RAMP_STEP) exp_q.push_back(8'(v));
        exp_q.push_back(8'd0);
        prev = pump_speed;
        req_auto = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (pump_speed !== prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL ramp_down unexpected speed %0d", pump_speed);
                end else begin
                    e = exp_q.pop_front();
                    if (pump_speed !== e) begin errors++; $display("FAIL ramp_down speed got %0d want %0d", pump_speed, e); end
                end
                prev = pump_speed;
            end
            if (state === S_COOL) break;
        end
        checks++; if (exp_q.size() != 0 || state !== S_COOL) begin
            errors++; $display("FAIL ramp_down_end left %0d state %0d want 0 left state 4", exp_q.size(), state);
        end
        exp_q.delete();
        // A request raised during cooldown must wait for IDLE
        req_auto = 1'b1;
        n = 1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (state !== S_COOL) break;
            n++;
        end
        checks++; if (state !== S_IDLE) begin errors++; $display("FAIL cooldown_exit state got %0d want 0", state); end
        checks++; if (n < (COOLDOWN_MS - 1) * TICK_DIV + 1 || n > COOLDOWN_MS * TICK_DIV) begin
            errors++; $display("FAIL cooldown_len got %0d cycles want %0d..%0d", n, (COOLDOWN_MS - 1) * TICK_DIV + 1, COOLDOWN_MS * TICK_DIV);
        end
        wait_state(S_UP, 2, ok);
        checks++; if (!ok) begin errors++; $display("FAIL cooldown_restart state got %0d want 1", state); end
    endtask

    task automatic test_fault();
        bit ok;
        for (int c = 0; c < 100 && pump_speed < 8'd32; c++) @(negedge clk);
        dry_fault = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (state !== S_UP) begin errors++; $display("FAIL fault_sync_latency state got %0d want 1", state); end
        @(negedge clk);
        checks++; if (state !== S_FAULT || pump_en !== 1'b0 || pump_speed !== 8'd0) begin
            errors++; $display("FAIL fault_entry state/en/speed got %0d/%b/%0d want 5/0/0", state, pump_en, pump_speed);
        end
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        @(negedge clk);
        checks++; if (state !== S_FAULT) begin errors++; $display("FAIL fault_clr_ignored state got %0d want 5", state); end
        req_auto  = 1'b0;
        dry_fault = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (state !== S_FAULT) begin errors++; $display("FAIL fault_holds state got %0d want 5", state); end
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        checks++; if (state !== S_COOL) begin errors++; $display("FAIL fault_clr_exit state got %0d want 4", state); end
        wait_state(S_IDLE, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL fault_to_idle state got %0d want 0", state); end
    endtask

    task automatic test_manual_priority();
        logic [7:0] prev, e;
        manual_speed = 8'd40;
        req_manual   = 1'b1;
        // Raising auto two cycles later lines both requests up at the FSM on the same edge
        repeat (2) @(negedge clk);
        req_auto = 1'b1;
        exp_q.push_back(8'd16);
        exp_q.push_back(8'd32);
        exp_q.push_back(8'd40);
        prev = pump_speed;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (pump_speed !== prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL manual_ramp unexpected speed %0d", pump_speed);
                end else begin
                    e = exp_q.pop_front();
                    if (pump_speed !== e) begin errors++; $display("FAIL manual_ramp speed got %0d want %0d", pump_speed, e); end
                end
                prev = pump_speed;
            end
            if (state === S_RUN) break;
        end
        checks++; if (exp_q.size() != 0 || state !== S_RUN || pump_speed !== 8'd40) begin
            errors++; $display("FAIL manual_run left %0d state %0d speed %0d want 0 left state 2 speed 40", exp_q.size(), state, pump_speed);
        end
        exp_q.delete();
    endtask

    task automatic test_stop();
        logic [7:0] prev, e;
        bit ok;
        exp_q.push_back(8'd24);
        exp_q.push_back(8'd8);
        exp_q.push_back(8'd0);
        prev = pump_speed;
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        checks++; if (state !== S_DOWN) begin errors++; $display("FAIL stop_entry state got %0d want 3", state); end
        for (int c = 0; c < 200; c++) begin
            if (pump_speed !== prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL stop_ramp unexpected speed %0d", pump_speed);
                end else begin
                    e = exp_q.pop_front();
                    if (pump_speed !== e) begin errors++; $display("FAIL stop_ramp speed got %0d want %0d", pump_speed, e); end
                end
                prev = pump_speed;
            end
            if (state === S_COOL) break;
            @(negedge clk);
        end
        checks++; if (exp_q.size() != 0 || state !== S_COOL || pump_en !== 1'b0) begin
            errors++; $display("FAIL stop_end left %0d state %0d en %b want 0 left state 4 en 0", exp_q.size(), state, pump_en);
        end
        exp_q.delete();
        req_manual = 1'b0;
        req_auto   = 1'b0;
        wait_state(S_IDLE, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stop_to_idle state got %0d want 0", state); end
    endtask

    task automatic test_watchdog();
        bit ok;
        int n;
        req_auto = 1'b1;
        wait_state(S_RUN, 300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL wd_reach_run state got %0d want 2", state); end
`ifdef PUMP_WATCHDOG_EN
        n = 1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (state !== S_RUN) break;
            n++;
        end
        checks++; if (state !== S_DOWN || timeout !== 1'b1) begin
            errors++; $display("FAIL wd_expire state/timeout got %0d/%b want 3/1", state, timeout);
        end
        checks++; if (n < (MAX_RUN_MS - 1) * TICK_DIV + 1 || n > MAX_RUN_MS * TICK_DIV) begin
            errors++; $display("FAIL wd_run_len got %0d cycles want %0d..%0d", n, (MAX_RUN_MS - 1) * TICK_DIV + 1, MAX_RUN_MS * TICK_DIV);
        end
        wait_state(S_COOL, 300, ok);
        checks++; if (!ok || timeout !== 1'b1) begin errors++; $display("FAIL wd_sticky_cool state/timeout got %0d/%b want 4/1", state, timeout); end
        wait_state(S_IDLE, 40, ok);
        checks++; if (!ok || timeout !== 1'b1) begin errors++; $display("FAIL wd_sticky_idle state/timeout got %0d/%b want 0/1", state, timeout); end
        @(negedge clk);
        checks++; if (state !== S_UP || timeout !== 1'b0) begin
            errors++; $display("FAIL wd_clear_on_start state/timeout got %0d/%b want 1/0", state, timeout);
        end
`else
        n = 0;
        for (int c = 0; c < 8 * TICK_DIV * MAX_RUN_MS / 5; c++) begin
            @(negedge clk);
            if (state !== S_RUN || timeout !== 1'b0) n++;
        end
        checks++; if (n != 0) begin errors++; $display("FAIL no_wd_run_holds left RUN/timeout set in %0d cycles want 0", n); end
`endif
        req_auto = 1'b0;
        wait_state(S_IDLE, 400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL wd_to_idle state got %0d want 0", state); end
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        req_auto = 1'b1;
        wait_state(S_RUN, 300, ok);
        checks++; if (!ok || pump_speed !== 8'(AUTO_SPEED)) begin
            errors++; $display("FAIL rst_reach_run state/speed got %0d/%0d want 2/200", state, pump_speed);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (pump_en !== 1'b0 || pump_speed !== 8'd0 || state !== S_IDLE) begin
            errors++; $display("FAIL rst_async en/speed/state got %b/%0d/%0d want 0/0/0", pump_en, pump_speed, state);
        end
        @(negedge clk);
        req_auto = 1'b0;
        reset_n  = 1'b1;
        @(negedge clk);
        checks++; if (state !== S_IDLE) begin errors++; $display("FAIL rst_release state got %0d want 0", state); end
    endtask

    initial begin
        reset_n      = 1'b0;
        req_manual   = 1'b0;
        req_auto     = 1'b0;
        stop         = 1'b0;
        dry_fault    = 1'b0;
        fault_clr    = 1'b0;
        manual_speed = 8'd0;
        repeat (3) @(negedge clk);
        test_reset();
        reset_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_auto_ramp();
        test_drop_cooldown();
        test_fault();
        test_manual_priority();
        test_stop();
        test_watchdog();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pump_sequencer.md
PUMP_SEQUENCER -- requirements
Module: pump_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 50000: clk cycles per 1 ms tick at 50 MHz.
REQ-002 Parameter RAMP_STEP, default 8: speed increment/decrement per tick.
REQ-003 Parameter AUTO_SPEED, default 200: target speed for auto requests.
REQ-004 Parameter COOLDOWN_MS, default 2000: mandatory off time in ticks.
REQ-005 Parameter MAX_RUN_MS, default 60000: watchdog run limit in ticks.
REQ-006 clk  in  1  system clock, 50 MHz.
REQ-007 reset_n  in  1  reset, asynchronous, active-low.
REQ-008 req_manual  in  1  asynchronous level, manual pump request.
REQ-009 manual_speed  in  8  manual target speed, sampled at start.
REQ-010 req_auto  in  1  synchronous level, auto (moisture) request.
REQ-011 stop  in  1  synchronous one-cycle pulse, graceful stop.
REQ-012 dry_fault  in  1  asynchronous level, reservoir low.
REQ-013 fault_clr  in  1  synchronous pulse, acknowledge fault.
REQ-014 pump_en  out  1  enable to the motor driver.
REQ-015 pump_speed  out  8  speed to the motor driver.
REQ-016 state  out  3  current FSM state encoding.
REQ-017 timeout  out  1  sticky flag, watchdog expired.

Function
REQ-018 req_manual and dry_fault SHALL pass through 2-flop synchronizers; the FSM SHALL see them 2 cycles after the input changes.
REQ-019 The tick counter SHALL count 0..TICK_DIV-1 and free-run; tick SHALL be high for one cycle when the count equals TICK_DIV-1.
REQ-020 The FSM SHALL have states IDLE=0, RAMP_UP=1, RUN=2, RAMP_DOWN=3, COOLDOWN=4, FAULT=5.
REQ-021 IDLE: a synchronized req_manual with manual_speed!=0 SHALL latch target=manual_speed; otherwise req_auto SHALL latch target=AUTO_SPEED. Manual wins on simultaneous requests. The FSM SHALL then enter RAMP_UP, clear timeout and clear the run counter.
REQ-022 RAMP_UP: on each tick, pump_speed SHALL become min(pump_speed+RAMP_STEP, target) using 9-bit arithmetic with no 8-bit wrap. The FSM SHALL enter RUN on the cycle after pump_speed equals target.
REQ-023 RUN: pump_speed SHALL hold target. If the originating request drops or stop pulses, the FSM SHALL enter RAMP_DOWN.
REQ-024 A request drop or stop during RAMP_UP SHALL enter RAMP_DOWN from the current speed.
REQ-025 RAMP_DOWN: on each tick, pump_speed SHALL become max(pump_speed-RAMP_STEP, 0). At 0 the FSM SHALL enter COOLDOWN.
REQ-026 COOLDOWN: the FSM SHALL count COOLDOWN_MS ticks, ignore all requests, then enter IDLE.
REQ-027 pump_en SHALL be 1 only in RAMP_UP, RUN and RAMP_DOWN.
REQ-028 A synchronized dry_fault SHALL force FAULT from any state, with pump_en=0 and pump_speed=0 on the next clock.
REQ-029 FAULT SHALL exit to COOLDOWN only on fault_clr while dry_fault is deasserted. A fault_clr pulse while dry_fault is still asserted SHALL be ignored.
REQ-030 Priority SHALL be: dry_fault > stop > request changes > tick.

Reset
REQ-031 On reset_n low: state=IDLE, pump_en=0, pump_speed=0, timeout=0, target=0, all counters 0, synchronizers 0; asynchronously and immediately, including mid-ramp.

Configuration
REQ-032 With PUMP_WATCHDOG_EN defined, the run counter SHALL count ticks in RUN. On reaching MAX_RUN_MS it SHALL set timeout and enter RAMP_DOWN.
REQ-033 Without PUMP_WATCHDOG_EN, the run counter SHALL not exist, timeout SHALL be tied to 0, and RUN SHALL last indefinitely.

Structure
REQ-034 State encodings and default parameter constants SHALL live in the shared package pump_pkg.
REQ-035 The tick prescaler SHALL be the sub-module ms_tick_gen (parameter TICK_DIV, output tick).

Verification (bench parameters: TICK_DIV=10, RAMP_STEP=16, AUTO_SPEED=200, COOLDOWN_MS=3, MAX_RUN_MS=5)
REQ-036 req_auto=1 -> RAMP_UP; speed 16,32,...,192,200 over 13 ticks; then RUN with pump_en=1 and speed=200.
REQ-037 req_manual=1, manual_speed=40, and req_auto=1 together -> target 40, reached in 3 ticks (16, 32, 40).
REQ-038 Drop req_auto in RUN -> speed steps down to 0, then COOLDOWN for 30 cycles; a request during COOLDOWN is ignored until IDLE.
REQ-039 dry_fault=1 mid-RAMP_UP -> pump_en=0 and speed=0 by 3 cycles later; fault_clr while dry_fault=1 is ignored; after dry_fault=0 and fault_clr -> COOLDOWN.
REQ-040 With PUMP_WATCHDOG_EN, hold req_auto -> 5 ticks into RUN, timeout=1 and RAMP_DOWN; timeout stays 1 until the next start.
REQ-041 Assert reset_n low in RUN at speed 200 -> pump_en=0 and speed=0 with no clock edge; state=IDLE.
